// File: rtl/digit_serial_adder.sv
// Digit-serial unsigned adder: one 2-bit slice (two chained full-adder cells)
// consumes a digit per clock; O = {carry, sum} is written only on completion.

module dsa_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   O
);
   localparam int D  = WIDTH / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, res, res_d;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [2:0]       c;
   logic [1:0]       s;
   logic             load, fin;

   assign c[0] = carry;

   for (genvar i = 0; i < 2; i++) begin : g_cell
      dsa_fa_cell u_fa (
         .a  (a_sr[i]),
         .b  (b_sr[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // Sum digits enter at the top so the last digit lands in the MSBs.
   if (WIDTH == 2) begin : g_res_min
      assign res_d = s;
   end else begin : g_res_wide
      assign res_d = {s, res[WIDTH-1:2]};
   end

   assign fin = (state == RUN) && (cnt == CW'(D - 1));

   always_comb begin
      state_d = state;
      load    = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_d = RUN;
            load    = 1'b1;
         end
         RUN:  if (fin) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         O     <= '0;
      end else begin
         done <= fin;
         busy <= (state_d == RUN);
         if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
         end else if (state == RUN) begin
            a_sr  <= a_sr >> 2;
            b_sr  <= b_sr >> 2;
            res   <= res_d;
            carry <= c[2];
            cnt   <= cnt + CW'(1);
            if (fin) O <= {c[2], res_d};
         end
      end
   end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: WIDTH=8 and WIDTH=2 instances checked every
// cycle against a cycle-count/arithmetic model, plus directed literal checks.

module tb_digit_serial_adder;
   logic       clk, rst_n;
   logic       s8, s2;
   logic [7:0] a8, b8;
   logic [1:0] a2, b2;
   logic       busy8, done8, busy2, done2;
   logic [8:0] o8;
   logic [2:0] o2;

   int checks = 0;
   int failures = 0;

   digit_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .O(o8));

   digit_serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .O(o2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Model: an accepted operation completes D edges later with O = A + B.
   int         m8_rem, m2_rem;
   logic [8:0] m8_acc, m8_o;
   logic [2:0] m2_acc, m2_o;
   logic       m8_done, m2_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_rem <= 0; m8_acc <= '0; m8_o <= '0; m8_done <= 1'b0;
      end else begin
         m8_done <= 1'b0;
         if (m8_rem == 0) begin
            if (s8) begin
               m8_acc <= {1'b0, a8} + {1'b0, b8};
               m8_rem <= 4;
            end
         end else begin
            m8_rem <= m8_rem - 1;
            if (m8_rem == 1) begin
               m8_o    <= m8_acc;
               m8_done <= 1'b1;
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_rem <= 0; m2_acc <= '0; m2_o <= '0; m2_done <= 1'b0;
      end else begin
         m2_done <= 1'b0;
         if (m2_rem == 0) begin
            if (s2) begin
               m2_acc <= {1'b0, a2} + {1'b0, b2};
               m2_rem <= 1;
            end
         end else begin
            m2_rem <= m2_rem - 1;
            if (m2_rem == 1) begin
               m2_o    <= m2_acc;
               m2_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("w8_busy", busy8, m8_rem != 0);
      check("w8_done", done8, m8_done);
      check("w8_o",    o8,    m8_o);
      check("w2_busy", busy2, m2_rem != 0);
      check("w2_done", done2, m2_done);
      check("w2_o",    o2,    m2_o);
      check("busy_done_excl", busy8 & done8, 0);
   end

   task automatic wait_done(input bit w2, output int nbusy, output int ncyc);
      nbusy = 0;
      ncyc  = 0;
      do begin
         @(negedge clk);
         ncyc++;
         if (w2 ? busy2 : busy8) nbusy++;
      end while (!(w2 ? done2 : done8) && ncyc < 20);
      check("done_seen", w2 ? done2 : done8, 1);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, output int nbusy);
      int nc;
      @(negedge clk);
      a8 = a; b8 = b; s8 = 1'b1;
      @(posedge clk);
      #1 s8 = 1'b0;
      wait_done(1'b0, nbusy, nc);
   endtask

   task automatic op2(input logic [1:0] a, input logic [1:0] b, output int nbusy);
      int nc;
      @(negedge clk);
      a2 = a; b2 = b; s2 = 1'b1;
      @(posedge clk);
      #1 s2 = 1'b0;
      wait_done(1'b1, nbusy, nc);
   endtask

   initial begin
      int nb, nc, nd, k;
      logic [8:0] o_at_done;
      rst_n = 1'b0;
      s8 = 1'b0; a8 = '0; b8 = '0;
      s2 = 1'b0; a2 = '0; b2 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_o", o8, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", busy8, 0);
      check("idle_o", o8, 0);

      // basic add
      op8(8'h5A, 8'h33, nb);
      check("basic_busy_cycles", nb, 4);
      check("basic_o", o8, 9'h08D);
      repeat (3) @(negedge clk);
      check("basic_hold", o8, 9'h08D);

      // carry chain; per-cycle compare covers O holding during RUN
      op8(8'hFF, 8'h01, nb);
      check("carry_o1", o8, 9'h100);
      op8(8'hFF, 8'hFF, nb);
      check("carry_o2", o8, 9'h1FE);

      // start and operand changes during RUN are ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; s8 = 1'b1;
      @(posedge clk);
      #1 s8 = 1'b0;
      @(negedge clk);
      s8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
      @(negedge clk);
      @(negedge clk);
      s8 = 1'b0;
      nd = 0; o_at_done = '0;
      repeat (10) begin
         @(negedge clk);
         if (done8) begin nd++; o_at_done = o8; end
      end
      check("run_done_count", nd, 1);
      check("run_o", o_at_done, 9'h030);

      // start held high: back-to-back acceptance in the done cycle
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h02; s8 = 1'b1;
      wait_done(1'b0, nb, nc);
      k = 0;
      do begin @(negedge clk); k++; end while (!done8 && k < 20);
      check("b2b_period", k, 5);
      check("b2b_o", o8, 9'h003);
      s8 = 1'b0;
      repeat (3) @(negedge clk);

      // reset mid-operation
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'h0F; s8 = 1'b1;
      @(posedge clk);
      #1 s8 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_o", o8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (done8) nd++;
      end
      check("abort_no_done", nd, 0);
      check("abort_idle", busy8, 0);

      // minimum width
      op2(2'd3, 2'd3, nb);
      check("w2_busy_cycles", nb, 1);
      check("w2_o_6", o2, 3'd6);
      op2(2'd0, 2'd0, nb);
      check("w2_o_0", o2, 3'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
